rf_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the 32x32 register file. Shares the file's single write port between NUM_REQ result producers (ALU, load unit, multi-cycle unit) using round-robin arbitration and a registered write stage. Tracks destination registers with outstanding results, and stalls decode on RAW and WAW hazards. Sits between the execute units and the register file write inputs (write_enable, rd, data_write).

---
 rtl/rf_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/rf_wb_sched.sv | 98 +++++++++
 tb/tb_rf_wb_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Widths here describe the 32x32 integer register file.
package rf_sched_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(
    input logic [REG_ADDR_W-1:0] r
  );
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
// The pointer moves only when a grant is actually taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic          hit;

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    sel   = ptr;
    for (int i = 0; i < N; i++) begin
      if (!hit && req[(int'(ptr) + i) % N]) begin
        hit = 1'b1;
        sel = PW'((int'(ptr) + i) % N);
      end
    end
    if (hit) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && hit) begin
      ptr <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: shares the register-file write port between
// result producers and tracks pending destinations for decode stalls.
module rf_wb_sched #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = rf_sched_pkg::XLEN,
  parameter int REG_ADDR_W = rf_sched_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic [REG_ADDR_W-1:0]         rs1,
  input  logic [REG_ADDR_W-1:0]         rs2,
  input  logic                          rs1_enable,
  input  logic                          rs2_enable,
  output logic                          raw_stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wb_enable,
  output logic [REG_ADDR_W-1:0]         wb_rd,
  output logic [XLEN-1:0]               wb_data,
  output logic [rf_sched_pkg::NUM_REGS-1:0] busy_mask
);

  import rf_sched_pkg::*;

  logic [NUM_REQ-1:0]  grant;
  wb_req_t             sel;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req_valid),
    .advance(1'b1),
    .grant  (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel.data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // rd=0 is consumed but never reaches the register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_enable <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      wb_enable <= (|grant) && (sel.rd != REG_ZERO);
      if (|grant) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
    end
  end

  assign issue_ready =
    !((issue_rd != REG_ZERO) && busy[issue_rd]);

  assign set_mask =
    (issue_valid && issue_ready && issue_rd != REG_ZERO)
      ? reg_bit(issue_rd) : '0;

  assign clr_mask = wb_enable ? reg_bit(wb_rd) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask)
              & ~NUM_REGS'(1);
    end
  end

  // no bypass: stall holds until the write has landed
  assign raw_stall =
    (rs1_enable && rs1 != REG_ZERO && busy[rs1]) ||
    (rs2_enable && rs2 != REG_ZERO && busy[rs2]);

  assign busy_mask = busy;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: vector table for the stall
// logic, hand sequences plus a write-back scoreboard queue.
module tb_rf_wb_sched;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_enable;
  logic        rs2_enable;
  logic        raw_stall;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;

  logic [4:0]  rd_v [3];
  logic [31:0] data_v [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  typedef struct {
    logic [4:0] rs1;
    logic       en1;
    logic [4:0] rs2;
    logic       en2;
    logic [4:0] ird;
    logic       raw;
    logic       rdy;
  } vec_t;

  vec_t vecs [8];

  assign req_rd   = {rd_v[2], rd_v[1], rd_v[0]};
  assign req_data = {data_v[2], data_v[1], data_v[0]};

  rf_wb_sched #(
    .NUM_REQ(3),
    .XLEN(32),
    .REG_ADDR_W(5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_enable (rs1_enable),
    .rs2_enable (rs2_enable),
    .raw_stall  (raw_stall),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_enable  (wb_enable),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .busy_mask  (busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, want);
    end
  endtask

  // Negedge sample: check grant, retire last expected write, queue next.
  task automatic sample(input logic [2:0] want_ready);
    wb_exp_t e;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(want_ready));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wb_enable", 32'(wb_enable), 32'(e.en));
      if (e.ld) begin
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
    end
    e = '{ld: 1'b0, en: 1'b0, rd: 5'd0, data: 32'd0};
    for (int i = 0; i < 3; i++) begin
      if (want_ready[i]) begin
        e.ld   = 1'b1;
        e.en   = (rd_v[i] != 5'd0);
        e.rd   = rd_v[i];
        e.data = data_v[i];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [2:0] want_ready);
    sample(want_ready);
    adv();
  endtask

  initial begin
    vecs[0] = '{5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1};
    vecs[1] = '{5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    vecs[2] = '{5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0};
    vecs[3] = '{5'd7, 1'b0, 5'd7, 1'b0, 5'd3, 1'b0, 1'b1};
    vecs[4] = '{5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0};
    vecs[5] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1};
    vecs[6] = '{5'd6, 1'b1, 5'd7, 1'b0, 5'd8, 1'b0, 1'b1};
    vecs[7] = '{5'd0, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0};

    reset_n     = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
    rs1_enable  = 1'b0;
    rs2_enable  = 1'b0;
    req_valid   = '0;
    for (int i = 0; i < 3; i++) begin
      rd_v[i]   = '0;
      data_v[i] = '0;
    end

    #3;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_wb_en", 32'(wb_enable), 32'h0);
    check("rst_wb_rd", 32'(wb_rd), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    #9 reset_n = 1'b1;
    adv();

    // round robin, all three requesting
    rd_v[0] = 5'd1; data_v[0] = 32'hA;
    rd_v[1] = 5'd2; data_v[1] = 32'hB;
    rd_v[2] = 5'd3; data_v[2] = 32'hC;
    req_valid = 3'b111;
    cyc(3'b001);
    cyc(3'b010);
    cyc(3'b100);
    cyc(3'b001);
    req_valid = 3'b000;
    cyc(3'b000);
    cyc(3'b000);

    // fill scoreboard with x5, x7
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    sample(3'b000);
    check("issue5_ready", 32'(issue_ready), 32'h1);
    adv();
    issue_rd = 5'd7;
    cyc(3'b000);
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    sample(3'b000);
    check("busy_5_7", busy_mask, 32'h0000_00A0);
    adv();

    for (int i = 0; i < 8; i++) begin
      rs1        = vecs[i].rs1;
      rs1_enable = vecs[i].en1;
      rs2        = vecs[i].rs2;
      rs2_enable = vecs[i].en2;
      issue_rd   = vecs[i].ird;
      sample(3'b000);
      check($sformatf("vec%0d_raw", i),
            32'(raw_stall), 32'(vecs[i].raw));
      check($sformatf("vec%0d_issue_ready", i),
            32'(issue_ready), 32'(vecs[i].rdy));
      adv();
    end
    rs1_enable = 1'b0;
    rs2_enable = 1'b0;

    // WAW on x7, held until its write-back lands
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    sample(3'b000);
    check("waw_ready", 32'(issue_ready), 32'h0);
    adv();
    sample(3'b000);
    check("waw_busy", busy_mask, 32'h0000_00A0);
    adv();
    rd_v[1] = 5'd7; data_v[1] = 32'h77;
    req_valid = 3'b010;
    sample(3'b010);
    check("waw_ready_g", 32'(issue_ready), 32'h0);
    adv();
    req_valid = 3'b000;
    sample(3'b000);
    check("waw_ready_wb", 32'(issue_ready), 32'h0);
    adv();
    sample(3'b000);
    check("waw_ready_rel", 32'(issue_ready), 32'h1);
    check("waw_busy_rel", busy_mask, 32'h0000_0020);
    adv();
    sample(3'b000);
    check("waw_busy_reset", busy_mask, 32'h0000_00A0);
    check("waw_ready_again", 32'(issue_ready), 32'h0);
    adv();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;

    // RAW on x5, released the cycle after its write
    rs1        = 5'd5;
    rs1_enable = 1'b1;
    rd_v[2] = 5'd5; data_v[2] = 32'h55;
    req_valid = 3'b100;
    sample(3'b100);
    check("raw_pre", 32'(raw_stall), 32'h1);
    adv();
    req_valid = 3'b000;
    sample(3'b000);
    check("raw_during_wb", 32'(raw_stall), 32'h1);
    adv();
    sample(3'b000);
    check("raw_after_wb", 32'(raw_stall), 32'h0);
    check("raw_busy", busy_mask, 32'h0000_0080);
    adv();
    rs1_enable = 1'b0;
    rs1        = 5'd0;

    // concurrent set x9 / clear x4
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    cyc(3'b000);
    issue_valid = 1'b0;
    rd_v[0] = 5'd4; data_v[0] = 32'h44;
    req_valid = 3'b001;
    cyc(3'b001);
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    sample(3'b000);
    check("cc_issue_ready", 32'(issue_ready), 32'h1);
    adv();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    sample(3'b000);
    check("cc_busy", busy_mask, 32'h0000_0280);
    adv();

    // x0 never becomes busy and is written silently
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    sample(3'b000);
    check("x0_issue_ready", 32'(issue_ready), 32'h1);
    adv();
    issue_valid = 1'b0;
    rd_v[1] = 5'd0; data_v[1] = 32'hDEAD_BEEF;
    req_valid = 3'b010;
    sample(3'b010);
    check("x0_busy", busy_mask, 32'h0000_0280);
    adv();
    req_valid = 3'b000;
    cyc(3'b000);

    // build busy=0xF0 with a write in flight, then async reset
    issue_valid = 1'b1;
    issue_rd = 5'd4; cyc(3'b000);
    issue_rd = 5'd5; cyc(3'b000);
    issue_rd = 5'd6; cyc(3'b000);
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rd_v[2] = 5'd9; data_v[2] = 32'h99;
    req_valid = 3'b100;
    cyc(3'b100);
    rd_v[0] = 5'd1; data_v[0] = 32'h11;
    req_valid = 3'b001;
    cyc(3'b001);
    req_valid = 3'b000;
    check("pre_rst_busy", busy_mask, 32'h0000_00F0);
    check("pre_rst_wb_en", 32'(wb_enable), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy_mask, 32'h0);
    check("arst_wb_en", 32'(wb_enable), 32'h0);
    check("arst_wb_rd", 32'(wb_rd), 32'h0);
    check("arst_wb_data", wb_data, 32'h0);
    exp_q.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    adv();
    req_valid = 3'b111;
    cyc(3'b001);
    req_valid = 3'b000;
    cyc(3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
